// File: rtl/axi_bw_monitor_pkg.sv
// Shared types and helpers for the AXI bandwidth monitor.
// Optional report build: define AXI_BW_MONITOR_REPORT_EN.
package axi_bw_monitor_pkg;

  localparam int unsigned DefaultCntWidth = 32;
  localparam int unsigned DefaultIdWidth  = 4;
  localparam int unsigned DataBytes       = 8;

  typedef logic [DefaultIdWidth-1:0] axi_id_t;

  typedef struct packed {
    logic    aw_valid;
    axi_id_t aw_id;
    logic    w_valid;
    logic    ar_valid;
    axi_id_t ar_id;
    logic    b_ready;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    ar_ready;
    logic    b_valid;
    axi_id_t b_id;
    logic    r_valid;
    axi_id_t r_id;
    logic    r_last;
  } axi_rsp_t;

  // Clamp a+b to max; computed one bit wider so the carry is never lost.
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] max
  );
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[63:0];
  endfunction

endpackage

// File: rtl/bw_sat_counter.sv
// Up/down counter that saturates at both ends.
// err pulses on a blocked step when limit errors are enabled.
module bw_sat_counter
  import axi_bw_monitor_pkg::*;
#(
  parameter int unsigned Width      = DefaultCntWidth,
  parameter bit          ErrOnLimit = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] cnt,
  output logic             err
);

  localparam logic [Width-1:0] Max = '1;

  logic [Width-1:0] q, d;
  logic             limit;

  always_comb begin
    d     = q;
    limit = 1'b0;
    case ({inc, dec})
      2'b10: begin
        limit = (q == Max);
        d     = Width'(sat_add(64'(q), 64'd1, 64'(Max)));
      end
      2'b01: begin
        limit = (q == '0);
        if (!limit) d = q - Width'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

  assign cnt = q;
  assign err = ErrOnLimit && limit;

endmodule

// File: rtl/axi_bandwidth_monitor.sv
// Passive AXI monitor: in-flight tracking, beat/cycle stats.
// Define AXI_BW_MONITOR_REPORT_EN for an end-of-sim report.
module axi_bandwidth_monitor
  import axi_bw_monitor_pkg::*;
#(
  parameter type         req_t      = axi_req_t,
  parameter type         rsp_t      = axi_rsp_t,
  parameter int unsigned AxiIdWidth = DefaultIdWidth,
  parameter int unsigned CntWidth   = DefaultCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                end_of_sim_i,
  input  req_t                req_i,
  input  rsp_t                rsp_i,
  output logic [CntWidth-1:0] ar_in_flight_o,
  output logic [CntWidth-1:0] aw_in_flight_o,
  output logic [CntWidth-1:0] r_beats_o,
  output logic [CntWidth-1:0] w_beats_o,
  output logic [CntWidth-1:0] cycles_o,
  output logic                done_o,
  output logic                error_o
);

  localparam int unsigned Ids = 2 ** AxiIdWidth;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic [AxiIdWidth-1:0] ar_id, aw_id, r_id, b_id;

  assign ar_hs = req_i.ar_valid && rsp_i.ar_ready;
  assign aw_hs = req_i.aw_valid && rsp_i.aw_ready;
  assign w_hs  = req_i.w_valid  && rsp_i.w_ready;
  assign r_hs  = rsp_i.r_valid  && req_i.r_ready;
  assign b_hs  = rsp_i.b_valid  && req_i.b_ready;

  assign ar_id = AxiIdWidth'(req_i.ar_id);
  assign aw_id = AxiIdWidth'(req_i.aw_id);
  assign r_id  = AxiIdWidth'(rsp_i.r_id);
  assign b_id  = AxiIdWidth'(rsp_i.b_id);

  logic [CntWidth-1:0] rd_cnt [Ids];
  logic [CntWidth-1:0] wr_cnt [Ids];
  logic [Ids-1:0]      rd_err, wr_err;

  logic done_q, err_q, window;
  logic r_zero, b_zero, r_ok, b_ok, orphan;
  logic ar_err, aw_err, rb_err, wb_err, cy_err;

  assign window = en_i && !done_q;

  // A response against an empty ID is an error and must not count down.
  assign r_zero = (rd_cnt[r_id] == '0);
  assign b_zero = (wr_cnt[b_id] == '0);
  assign r_ok   = r_hs && rsp_i.r_last && !r_zero;
  assign b_ok   = b_hs && !b_zero;
  assign orphan = (r_hs && r_zero) || (b_hs && b_zero);

  for (genvar g = 0; g < Ids; g++) begin : g_id
    bw_sat_counter #(.Width(CntWidth), .ErrOnLimit(1'b1)) u_rd (
      .clk (clk_i),
      .rst (rst_i),
      .inc (ar_hs && (ar_id == AxiIdWidth'(g))),
      .dec (r_ok  && (r_id  == AxiIdWidth'(g))),
      .cnt (rd_cnt[g]),
      .err (rd_err[g])
    );
    bw_sat_counter #(.Width(CntWidth), .ErrOnLimit(1'b1)) u_wr (
      .clk (clk_i),
      .rst (rst_i),
      .inc (aw_hs && (aw_id == AxiIdWidth'(g))),
      .dec (b_ok  && (b_id  == AxiIdWidth'(g))),
      .cnt (wr_cnt[g]),
      .err (wr_err[g])
    );
  end

  bw_sat_counter #(.Width(CntWidth), .ErrOnLimit(1'b1)) u_ar (
    .clk (clk_i),
    .rst (rst_i),
    .inc (ar_hs),
    .dec (r_ok),
    .cnt (ar_in_flight_o),
    .err (ar_err)
  );

  bw_sat_counter #(.Width(CntWidth), .ErrOnLimit(1'b1)) u_aw (
    .clk (clk_i),
    .rst (rst_i),
    .inc (aw_hs),
    .dec (b_ok),
    .cnt (aw_in_flight_o),
    .err (aw_err)
  );

  bw_sat_counter #(.Width(CntWidth), .ErrOnLimit(1'b0)) u_rb (
    .clk (clk_i),
    .rst (rst_i),
    .inc (window && r_hs),
    .dec (1'b0),
    .cnt (r_beats_o),
    .err (rb_err)
  );

  bw_sat_counter #(.Width(CntWidth), .ErrOnLimit(1'b0)) u_wb (
    .clk (clk_i),
    .rst (rst_i),
    .inc (window && w_hs),
    .dec (1'b0),
    .cnt (w_beats_o),
    .err (wb_err)
  );

  bw_sat_counter #(.Width(CntWidth), .ErrOnLimit(1'b0)) u_cy (
    .clk (clk_i),
    .rst (rst_i),
    .inc (window),
    .dec (1'b0),
    .cnt (cycles_o),
    .err (cy_err)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_q | end_of_sim_i;
      err_q  <= err_q | orphan | (|rd_err) | (|wr_err)
              | ar_err | aw_err | rb_err | wb_err | cy_err;
    end
  end

  assign done_o  = done_q;
  assign error_o = err_q;

`ifdef AXI_BW_MONITOR_REPORT_EN
  always @(posedge done_q) begin
    $display("axi_bw_monitor: cycles=%0d r_beats=%0d w_beats=%0d rd_B/cyc=%f wr_B/cyc=%f",
      cycles_o, r_beats_o, w_beats_o,
      (cycles_o == '0) ? 0.0 : real'(r_beats_o) * DataBytes / real'(cycles_o),
      (cycles_o == '0) ? 0.0 : real'(w_beats_o) * DataBytes / real'(cycles_o));
  end
`endif

endmodule

// File: tb/tb_axi_bandwidth_monitor.sv
// Self-checking bench for axi_bandwidth_monitor.
// Directed scenarios plus random traffic against a reference model.
module tb_axi_bandwidth_monitor;
  import axi_bw_monitor_pkg::*;

  localparam longint Max32 = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic eos = 1'b0;
  axi_req_t req;
  axi_rsp_t rsp;
  logic [31:0] ar_if, aw_if, rb, wb, cyc;
  logic done, err;

  logic en4 = 1'b0;
  logic eos4 = 1'b0;
  axi_req_t req4;
  axi_rsp_t rsp4;
  logic [3:0] ar_if4, aw_if4, rb4, wb4, cyc4;
  logic done4, err4;

  int n_pass = 0;
  int n_total = 0;

  longint m_ar, m_aw, m_rb, m_wb, m_cyc;
  int m_rd [16];
  int m_wr [16];
  bit m_err, m_done;

  always #5 clk = ~clk;

  axi_bandwidth_monitor #(
    .req_t(axi_req_t), .rsp_t(axi_rsp_t),
    .AxiIdWidth(4), .CntWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .end_of_sim_i(eos),
    .req_i(req), .rsp_i(rsp),
    .ar_in_flight_o(ar_if), .aw_in_flight_o(aw_if),
    .r_beats_o(rb), .w_beats_o(wb), .cycles_o(cyc),
    .done_o(done), .error_o(err)
  );

  axi_bandwidth_monitor #(
    .req_t(axi_req_t), .rsp_t(axi_rsp_t),
    .AxiIdWidth(4), .CntWidth(4)
  ) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en4), .end_of_sim_i(eos4),
    .req_i(req4), .rsp_i(rsp4),
    .ar_in_flight_o(ar_if4), .aw_in_flight_o(aw_if4),
    .r_beats_o(rb4), .w_beats_o(wb4), .cycles_o(cyc4),
    .done_o(done4), .error_o(err4)
  );

  function automatic longint sat(longint v);
    return (v > Max32) ? Max32 : v;
  endfunction

  task automatic model_reset();
    m_ar = 0; m_aw = 0; m_rb = 0; m_wb = 0; m_cyc = 0;
    m_err = 0; m_done = 0;
    for (int i = 0; i < 16; i++) begin
      m_rd[i] = 0;
      m_wr[i] = 0;
    end
  endtask

  // Applies the rules for one rising edge using the inputs held there.
  task automatic model_edge();
    bit win, arh, awh, wh, rh, bh, rdec, bdec;
    win  = en && !m_done;
    arh  = req.ar_valid && rsp.ar_ready;
    awh  = req.aw_valid && rsp.aw_ready;
    wh   = req.w_valid && rsp.w_ready;
    rh   = rsp.r_valid && req.r_ready;
    bh   = rsp.b_valid && req.b_ready;
    rdec = 0;
    bdec = 0;
    if (rh) begin
      if (m_rd[rsp.r_id] == 0) m_err = 1;
      else if (rsp.r_last) rdec = 1;
    end
    if (bh) begin
      if (m_wr[rsp.b_id] == 0) m_err = 1;
      else bdec = 1;
    end
    if (rdec) m_rd[rsp.r_id]--;
    if (arh) m_rd[req.ar_id]++;
    if (bdec) m_wr[rsp.b_id]--;
    if (awh) m_wr[req.aw_id]++;
    if (arh && !rdec && m_ar == Max32) m_err = 1;
    else m_ar = m_ar + arh - rdec;
    if (awh && !bdec && m_aw == Max32) m_err = 1;
    else m_aw = m_aw + awh - bdec;
    if (win) begin
      m_cyc = sat(m_cyc + 1);
      if (rh) m_rb = sat(m_rb + 1);
      if (wh) m_wb = sat(m_wb + 1);
    end
    if (eos) m_done = 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle();
    req = '0;
    rsp = '0;
  endtask

  task automatic do_reset();
    idle();
    en = 0;
    eos = 0;
    rst = 1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic drive_random();
    int id;
    idle();
    en = ($urandom_range(0, 4) != 0);
    req.ar_valid = ($urandom_range(0, 2) == 0);
    req.ar_id = 4'($urandom_range(0, 3));
    rsp.ar_ready = 1'($urandom);
    req.aw_valid = ($urandom_range(0, 2) == 0);
    req.aw_id = 4'($urandom_range(0, 3));
    rsp.aw_ready = 1'($urandom);
    req.w_valid = 1'($urandom);
    rsp.w_ready = 1'($urandom);
    id = $urandom_range(0, 3);
    rsp.r_id = 4'(id);
    rsp.r_valid = (m_rd[id] > 0) && 1'($urandom);
    rsp.r_last = 1'($urandom);
    req.r_ready = 1'($urandom);
    id = $urandom_range(0, 3);
    rsp.b_id = 4'(id);
    rsp.b_valid = (m_wr[id] > 0) && 1'($urandom);
    req.b_ready = 1'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_total++;
    if ({ar_if, aw_if, rb, wb, cyc, done, err} !== '0) begin
      $display("FAIL reset: got %h want 0",
        {ar_if, aw_if, rb, wb, cyc, done, err});
    end else n_pass++;
  endtask

  task automatic test_reads();
    int ids [4] = '{0, 1, 1, 2};
    for (int i = 0; i < 4; i++) begin
      idle();
      req.ar_valid = 1;
      req.ar_id = 4'(ids[i]);
      rsp.ar_ready = 1;
      step();
    end
    idle();
    n_total++;
    if (ar_if !== 32'd4) $display("FAIL ar_four: got %0d want 4", ar_if);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      idle();
      rsp.r_valid = 1;
      rsp.r_id = 4'd1;
      rsp.r_last = 1;
      req.r_ready = 1;
      step();
    end
    idle();
    n_total++;
    if (ar_if !== 32'd2) $display("FAIL ar_two: got %0d want 2", ar_if);
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL reads_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_aw_b_same_cycle();
    int ids [3] = '{3, 3, 4};
    for (int i = 0; i < 3; i++) begin
      idle();
      req.aw_valid = 1;
      req.aw_id = 4'(ids[i]);
      rsp.aw_ready = 1;
      step();
    end
    idle();
    n_total++;
    if (aw_if !== 32'd3) $display("FAIL aw_three: got %0d want 3", aw_if);
    else n_pass++;
    req.aw_valid = 1;
    req.aw_id = 4'd6;
    rsp.aw_ready = 1;
    rsp.b_valid = 1;
    rsp.b_id = 4'd3;
    req.b_ready = 1;
    step();
    idle();
    n_total++;
    if (aw_if !== 32'd3) $display("FAIL aw_b_same: got %0d want 3", aw_if);
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL aw_b_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_orphan_b();
    rsp.b_valid = 1;
    rsp.b_id = 4'd5;
    req.b_ready = 1;
    step();
    idle();
    n_total++;
    if (err !== 1'b1) $display("FAIL orphan_err: got %b want 1", err);
    else n_pass++;
    n_total++;
    if (aw_if !== 32'd3) $display("FAIL orphan_aw: got %0d want 3", aw_if);
    else n_pass++;
  endtask

  task automatic test_window();
    do_reset();
    req.ar_valid = 1;
    req.ar_id = 4'd0;
    rsp.ar_ready = 1;
    step();
    idle();
    en = 1;
    for (int i = 0; i < 100; i++) begin
      rsp.r_valid = (i < 64);
      rsp.r_id = 4'd0;
      rsp.r_last = (i == 63);
      req.r_ready = 1;
      step();
    end
    idle();
    en = 0;
    eos = 1;
    step();
    eos = 0;
    n_total++;
    if ({done, cyc, rb, err} !== {1'b1, 32'd100, 32'd64, 1'b0})
      $display("FAIL window: got done=%b cyc=%0d rb=%0d err=%b want 1/100/64/0",
        done, cyc, rb, err);
    else n_pass++;
    en = 1;
    for (int i = 0; i < 10; i++) begin
      idle();
      req.w_valid = 1;
      rsp.w_ready = 1;
      req.ar_valid = (i == 4);
      req.ar_id = 4'd1;
      rsp.ar_ready = 1;
      step();
    end
    idle();
    en = 0;
    n_total++;
    if ({done, cyc, rb, wb} !== {1'b1, 32'd100, 32'd64, 32'd0})
      $display("FAIL frozen: got done=%b cyc=%0d rb=%0d wb=%0d want 1/100/64/0",
        done, cyc, rb, wb);
    else n_pass++;
    n_total++;
    if (ar_if !== 32'd1) $display("FAIL post_done_ar: got %0d want 1", ar_if);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive_random();
      eos = (c == 350);
      step();
      n_total++;
      if ({ar_if, aw_if, rb, wb, cyc, done, err} !==
          {m_ar[31:0], m_aw[31:0], m_rb[31:0], m_wb[31:0],
           m_cyc[31:0], m_done, m_err})
        $display("FAIL random c%0d: got %h want %h", c,
          {ar_if, aw_if, rb, wb, cyc, done, err},
          {m_ar[31:0], m_aw[31:0], m_rb[31:0], m_wb[31:0],
           m_cyc[31:0], m_done, m_err});
      else n_pass++;
    end
    idle();
    eos = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    idle();
    req.ar_valid = 1;
    req.ar_id = 4'd2;
    rsp.ar_ready = 1;
    step();
    idle();
    en = 1;
    req.w_valid = 1;
    rsp.w_ready = 1;
    repeat (5) step();
    n_total++;
    if (ar_if !== 32'd1 || wb !== 32'd5)
      $display("FAIL pre_reset: got ar=%0d wb=%0d want 1/5", ar_if, wb);
    else n_pass++;
    #2;
    rst = 1;
    #1;
    n_total++;
    if ({ar_if, aw_if, rb, wb, cyc, done, err} !== '0)
      $display("FAIL async_reset: got %h want 0",
        {ar_if, aw_if, rb, wb, cyc, done, err});
    else n_pass++;
    idle();
    en = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    rsp.r_valid = 1;
    rsp.r_id = 4'd2;
    rsp.r_last = 1;
    req.r_ready = 1;
    step();
    idle();
    n_total++;
    if (err !== 1'b1 || ar_if !== 32'd0)
      $display("FAIL stale_resp: got err=%b ar=%0d want 1/0", err, ar_if);
    else n_pass++;
  endtask

  task automatic test_sat4();
    en4 = 1;
    req4.w_valid = 1;
    rsp4.w_ready = 1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    en4 = 0;
    req4 = '0;
    rsp4 = '0;
    n_total++;
    if (wb4 !== 4'd15) $display("FAIL sat4_w: got %0d want 15", wb4);
    else n_pass++;
    n_total++;
    if (cyc4 !== 4'd15) $display("FAIL sat4_cyc: got %0d want 15", cyc4);
    else n_pass++;
    n_total++;
    if (err4 !== 1'b0) $display("FAIL sat4_err: got %b want 0", err4);
    else n_pass++;
  endtask

  initial begin
    idle();
    req4 = '0;
    rsp4 = '0;
    model_reset();
    test_reset();
    test_reads();
    test_aw_b_same_cycle();
    test_orphan_b();
    test_window();
    test_random();
    test_async_reset();
    test_sat4();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_bandwidth_monitor.md
AXI_BANDWIDTH_MONITOR -- requirements
Module: axi_bandwidth_monitor

Interface
REQ-001 SHALL have parameter req_t, default logic, meaning AXI request struct (aw/w/ar valid and fields, b_ready, r_ready).
REQ-002 SHALL have parameter rsp_t, default logic, meaning AXI response struct (ready signals, b/r valid and fields).
REQ-003 SHALL have parameter AxiIdWidth, default 4, meaning AXI ID width, which sets the per-ID tracking depth to 2**AxiIdWidth.
REQ-004 SHALL have parameter CntWidth, default 32, meaning the width of every counter output.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk_i  in  1  the only clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 en_i  in  1  enables counting of statistics.
REQ-009 end_of_sim_i  in  1  freezes all statistics when high.
REQ-010 req_i  in  req_t  passively snooped request; never driven.
REQ-011 rsp_i  in  rsp_t  passively snooped response; never driven.
REQ-012 ar_in_flight_o  out  CntWidth  outstanding read transactions.
REQ-013 aw_in_flight_o  out  CntWidth  outstanding write transactions.
REQ-014 r_beats_o / w_beats_o  out  CntWidth  R and W beat handshakes counted in the window.
REQ-015 cycles_o  out  CntWidth  clock cycles counted in the window.
REQ-016 done_o  out  1  sticky flag meaning statistics are frozen.
REQ-017 error_o  out  1  sticky protocol-error flag.

Function
REQ-018 A handshake SHALL be valid&&ready sampled at the clk_i rising edge; the block SHALL add zero combinational paths to req_i/rsp_i.
REQ-019 The counting window SHALL be en_i && !done_o.
REQ-020 In-flight tracking SHALL ignore the window:
- ar_in_flight_o +1 per AR handshake, -1 per R handshake with r.last.
- aw_in_flight_o +1 per AW handshake, -1 per B handshake.
- Simultaneous increment and decrement SHALL leave the value unchanged.
REQ-021 Per-ID read/write outstanding counters SHALL be kept, indexed by ar.id/aw.id and by r.id/b.id.
REQ-022 A response for an ID whose outstanding count is 0 SHALL set error_o and leave counters unchanged (no underflow).
REQ-023 An increment at all-ones SHALL set error_o and saturate.
REQ-024 Inside the window, cycles_o +1 per cycle, r_beats_o +1 per R handshake, w_beats_o +1 per W handshake.
REQ-025 Beat and cycle counters SHALL saturate at 2**CntWidth-1 without setting error_o.
REQ-026 done_o SHALL set the cycle after end_of_sim_i is first seen high and stay set until reset; in-flight tracking continues after done_o.
REQ-027 All outputs SHALL be registered, with a latency of 1 cycle from handshake to output.

Reset
REQ-028 rst_i high SHALL asynchronously clear all counters, per-ID tables, done_o and error_o to 0.
REQ-029 Reset mid-transaction SHALL discard outstanding state; responses arriving afterwards SHALL raise error_o.

Configuration
REQ-030 When AXI_BW_MONITOR_REPORT_EN is defined, on the rising edge of done_o the block SHALL $display cycles, r_beats, w_beats, read bytes/cycle and write bytes/cycle (beats*DataBytes/cycles, 0 if cycles=0).
REQ-031 Without AXI_BW_MONITOR_REPORT_EN, no simulation-only code SHALL be compiled and the RTL SHALL be synthesizable.

Structure
REQ-032 Package axi_bw_monitor_pkg SHALL hold the counter-width default and the saturating-add function.
REQ-033 Sub-module bw_sat_counter (inc, dec, saturate, error flag) SHALL be instantiated for each counter.

Verification
REQ-034 Four AR handshakes (IDs 0,1,1,2) then two R last beats, id 1 -> ar_in_flight_o 4 then 2; error_o 0.
REQ-035 AW handshake and B handshake in the same cycle with in-flight at 3 -> aw_in_flight_o stays 3.
REQ-036 B handshake with id 5 and no outstanding write -> error_o=1 next cycle; aw_in_flight_o unchanged.
REQ-037 en_i high 100 cycles, 64 R beats, then end_of_sim_i pulse -> cycles_o=100, r_beats_o=64, done_o=1; values frozen afterwards.
REQ-038 rst_i asserted asynchronously mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
REQ-039 With CntWidth=4, 20 W beats -> w_beats_o=15, error_o 0.
